// File: rtl/workload_sink.sv
// workload_sink: receiving end of the workload valid/ready stream.
//   Buffers accepted workloads in a small FIFO. Models a compute engine that
//   stays busy for max(size,1) cycles per workload. Checks that IDs arrive in
//   order and counts completions.
// Ports:
//   clk_i        clock, all state on the rising edge
//   reset_n_i    asynchronous active-low reset
//   v_i/data_i   workload valid and {id, size}
//   ready_o      sink can accept this cycle (registered FIFO count based)
//   done_v_o     one-cycle pulse when a workload finishes; done_id_o its ID
//   completed_o  completions, saturating at workload_limit_p
//   all_done_o   completed_o == workload_limit_p (registered)
//   err_o        sticky order/overrun error; err_id_o ID that first caused it
// Configuration macro: WORKLOAD_SINK_TRACE_EN enables simulation-only trace prints.
`timescale 1ns/1ps
module workload_sink #(
  parameter int unsigned id_width_p       = 4,
  parameter int unsigned size_width_p     = 4,
  parameter int unsigned buf_els_p        = 2,
  parameter int unsigned workload_limit_p = 2,
  parameter int unsigned width_p          = id_width_p + size_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  v_i,
  input  logic [width_p-1:0]                    data_i,
  output logic                                  ready_o,
  output logic                                  done_v_o,
  output logic [id_width_p-1:0]                 done_id_o,
  output logic [$clog2(workload_limit_p+1)-1:0] completed_o,
  output logic                                  all_done_o,
  output logic                                  err_o,
  output logic [id_width_p-1:0]                 err_id_o
);

  localparam int unsigned PtrW  = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
  localparam int unsigned CntW  = $clog2(buf_els_p + 1);
  localparam int unsigned CompW = $clog2(workload_limit_p + 1);
  localparam logic [size_width_p:0] CntOne = {{size_width_p{1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // FIFO
  logic [width_p-1:0] mem_q [buf_els_p];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               live_q;  // low until the first edge after reset release
  logic               push, pop, fifo_ne;

  // Engine
  state_e                  state_q, state_d;
  logic [size_width_p:0]   cnt_q, cnt_d;
  logic [id_width_p-1:0]   cur_id_q, cur_id_d;
  logic                    last_busy;

  // Order check / completion tracking
  logic [id_width_p-1:0]   exp_id_q;
  logic                    err_q;
  logic [id_width_p-1:0]   err_id_q;
  logic [CompW-1:0]        completed_q, completed_d;
  logic                    all_done_q;

  logic [width_p-1:0]      head;
  logic [id_width_p-1:0]   head_id, rx_id;
  logic [size_width_p-1:0] head_size;
  logic                    rx_bad;

  assign ready_o   = live_q & (count_q < CntW'(buf_els_p));
  assign push      = v_i & ready_o;
  assign fifo_ne   = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_id   = head[width_p-1:size_width_p];
  assign head_size = head[size_width_p-1:0];
  assign rx_id     = data_i[width_p-1:size_width_p];
  assign rx_bad    = (rx_id != exp_id_q) | all_done_q;
  assign last_busy = (state_q == StBusy) && (cnt_q == CntOne);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q <= 1'b1;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(buf_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(buf_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Engine next state; a pop always loads cnt/cur_id from the FIFO head.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_id_d = cur_id_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_ne) pop = 1'b1;
      end
      StBusy: begin
        if (cnt_q > CntOne)  cnt_d   = cnt_q - CntOne;
        else if (fifo_ne)    pop     = 1'b1;
        else                 state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      state_d  = StBusy;
      cnt_d    = (head_size == '0) ? CntOne : {1'b0, head_size};
      cur_id_d = head_id;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cur_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_id_q <= cur_id_d;
    end
  end

  assign done_v_o  = last_busy;
  assign done_id_o = last_busy ? cur_id_q : '0;

  always_comb begin
    completed_d = completed_q;
    if (last_busy && (completed_q != CompW'(workload_limit_p))) completed_d = completed_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      exp_id_q    <= '0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
      completed_q <= '0;
      all_done_q  <= 1'b0;
    end else begin
      completed_q <= completed_d;
      all_done_q  <= (completed_d == CompW'(workload_limit_p));
      if (push) begin
        exp_id_q <= exp_id_q + 1'b1;
        if (rx_bad) begin
          err_q <= 1'b1;
          if (!err_q) err_id_q <= rx_id;
        end
      end
    end
  end

  assign completed_o = completed_q;
  assign all_done_o  = all_done_q;
  assign err_o       = err_q;
  assign err_id_o    = err_id_q;

`ifdef WORKLOAD_SINK_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (push) $display("Recv workload %d size %d at time %d", rx_id,
                         data_i[size_width_p-1:0], $time);
      if (last_busy) $display("Done workload %d at time %d", cur_id_q, $time);
      if (push && rx_bad && !err_q) $display("Error on workload %d at time %d", rx_id, $time);
    end
  end
`else
  // Trace prints disabled; no display statements compiled.
`endif

endmodule
